// File: rtl/seq_detect_param.sv
// seq_detect_param
//   Serial sync-word detector. Matches a runtime-programmable pattern of
//   1..MAX_LEN bits against the accepted bit stream. Detection can be
//   overlapping or non-overlapping, and matches are counted with saturation.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   reset        asynchronous active-low reset
//   inp_bit      serial data bit
//   inp_valid    inp_bit is accepted on a rising edge only while high
//   cfg_load     latch cfg_pattern/cfg_len and clear history
//   cfg_pattern  pattern; bit [len-1] is expected first, bit [0] last
//   cfg_len      pattern length (0 is treated as 1, >MAX_LEN as MAX_LEN)
//   overlap_en   1 = overlapping detection, 0 = restart after each match
//   clear        clear history, fill level and match counter
//   seq_seen     registered one-cycle pulse on a match
//   match_count  saturating match counter
//   cur_len      active pattern length
//   seq_sticky   (only with SEQ_DETECT_STICKY_EN) set on any match,
//                held until clear or reset
//
// Build option
//   SEQ_DETECT_STICKY_EN  adds the seq_sticky output and its flop.

module seq_detect_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inp_bit,
  input  logic               inp_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               overlap_en,
  input  logic               clear,
  output logic               seq_seen,
`ifdef SEQ_DETECT_STICKY_EN
  output logic               seq_sticky,
`endif
  output logic [CNT_W-1:0]   match_count,
  output logic [LW-1:0]      cur_len
);

  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

  // Only MAX_LEN-1 history bits are stored: the oldest bit of the
  // MAX_LEN-wide window is shifted out before it could ever be compared.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LW-1:0]      fill_q, fill_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LW-1:0]      len_q, len_d;
  logic               seen_q, seen_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept;
  logic [MAX_LEN-1:0] hist_n;
  logic [LW-1:0]      fill_inc;
  logic [MAX_LEN-1:0] mask;
  logic               match;
  logic [LW-1:0]      len_clamped;

  assign accept   = inp_valid & ~clear & ~cfg_load;
  assign hist_n   = {hist_q, inp_bit};
  assign fill_inc = (fill_q >= LEN_MAX) ? LEN_MAX : fill_q + LW'(1);
  // len_q == MAX_LEN shifts every bit out, giving an all-ones mask.
  assign mask     = ~({MAX_LEN{1'b1}} << len_q);
  assign match    = accept && (fill_inc >= len_q) &&
                    (((hist_n ^ pat_q) & mask) == '0);

  always_comb begin
    len_clamped = cfg_len;
    if (cfg_len == '0) begin
      len_clamped = LW'(1);
    end else if (cfg_len > LEN_MAX) begin
      len_clamped = LEN_MAX;
    end
  end

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    len_d  = len_q;
    seen_d = 1'b0;
    cnt_d  = cnt_q;

    if (cfg_load) begin
      pat_d = cfg_pattern;
      len_d = len_clamped;
    end

    if (clear || cfg_load) begin
      hist_d = '0;
      fill_d = '0;
      if (clear) begin
        cnt_d = '0;
      end
    end else if (accept) begin
      hist_d = hist_n[MAX_LEN-2:0];
      fill_d = (match && !overlap_en) ? '0 : fill_inc;
      seen_d = match;
      if (match && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= '0;
      len_q  <= LEN_MAX;
      seen_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      seen_q <= seen_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef SEQ_DETECT_STICKY_EN
  logic sticky_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sticky_q <= 1'b0;
    end else if (clear) begin
      sticky_q <= 1'b0;
    end else if (match) begin
      sticky_q <= 1'b1;
    end
  end

  assign seq_sticky = sticky_q;
`endif

  assign seq_seen    = seen_q;
  assign match_count = cnt_q;
  assign cur_len     = len_q;

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LW      = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               inp_bit = 1'b0;
  logic               inp_valid = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LW-1:0]      cfg_len = '0;
  logic               overlap_en = 1'b0;
  logic               clear = 1'b0;
  logic               seq_seen;
  logic [CNT_W-1:0]   match_count;
  logic [LW-1:0]      cur_len;
`ifdef SEQ_DETECT_STICKY_EN
  logic               seq_sticky;
`endif

  seq_detect_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .inp_bit     (inp_bit),
    .inp_valid   (inp_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .overlap_en  (overlap_en),
    .clear       (clear),
    .seq_seen    (seq_seen),
`ifdef SEQ_DETECT_STICKY_EN
    .seq_sticky  (seq_sticky),
`endif
    .match_count (match_count),
    .cur_len     (cur_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    int          cnt;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          exp_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every seq_seen pulse must match the oldest expected entry,
  // both in the cycle it appears and in the counter value alongside it.
  always @(negedge clk) begin
    if (reset && seq_seen) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: seq_seen=1 at cycle %0d, no pulse expected", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.cyc != cyc || int'(match_count) != e.cnt) begin
          n_fail++;
          $display("FAIL pulse: cycle %0d count %0d, expected cycle %0d count %0d",
                   cyc, match_count, e.cyc, e.cnt);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic b, input logic ld, input logic clr);
    @(negedge clk);
    inp_valid = v;
    inp_bit   = b;
    cfg_load  = ld;
    clear     = clr;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One accepted bit; if a match is expected, the pulse is due at the next
  // falling edge after the accepting rising edge.
  task automatic send(input logic b, input logic exp_pulse);
    drive(1'b1, b, 1'b0, 1'b0);
    if (exp_pulse) begin
      exp_t e;
      if (exp_cnt < 3) exp_cnt++;
      e.cyc = cyc + 1;
      e.cnt = exp_cnt;
      exp_q.push_back(e);
    end
  endtask

  // inp_valid/inp_bit are held high during configuration to show the bit is ignored.
  task automatic configure(input logic [MAX_LEN-1:0] pat, input logic [LW-1:0] len,
                           input logic clr);
    cfg_pattern = pat;
    cfg_len     = len;
    drive(1'b1, 1'b1, 1'b1, clr);
    if (clr) exp_cnt = 0;
    idle(1);
  endtask

  task automatic send_vec(input string name, input int n, input logic [15:0] bits,
                          input logic [15:0] pulses);
    for (int i = n - 1; i >= 0; i--) send(bits[i], pulses[i]);
    idle(3);
    check({name, "_missing_pulses"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #12;
    check("reset_seq_seen", seq_seen, 0);
    check("reset_count", match_count, 0);
    check("reset_cur_len", cur_len, MAX_LEN);
    @(negedge clk);
    reset = 1'b1;

    // overlapping: 1011011 -> pulses after bits 4 and 7
    overlap_en = 1'b1;
    configure(8'h0B, 4'd4, 1'b1);
    check("cfg_cur_len4", cur_len, 4);
    send_vec("overlap", 7, 16'b1011011, 16'b0001001);
    check("overlap_count", match_count, 2);

    // non-overlapping: same stream -> single pulse after bit 4
    overlap_en = 1'b0;
    configure(8'h0B, 4'd4, 1'b1);
    send_vec("nonoverlap", 7, 16'b1011011, 16'b0001000);
    check("nonoverlap_count", match_count, 1);

    // cfg_load alone keeps the counter; then bits separated by idle gaps
    configure(8'h0B, 4'd4, 1'b0);
    check("cfg_keeps_count", match_count, 1);
    send(1'b1, 1'b0); idle(3);
    send(1'b0, 1'b0); idle(3);
    send(1'b1, 1'b0); idle(3);
    send(1'b1, 1'b1); idle(3);
    check("gaps_missing_pulses", exp_q.size(), 0);
    exp_q.delete();
    check("gaps_count", match_count, 2);

    // length 0 clamps to 1, self-overlap of a single-bit pattern
    overlap_en = 1'b1;
    configure(8'h01, 4'd0, 1'b1);
    check("clamp_cur_len1", cur_len, 1);
    send_vec("clamp", 4, 16'b1101, 16'b1101);
    check("clamp_count", match_count, 3);

    // counter saturation: six matches, count stops at 3
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    exp_cnt = 0;
    idle(1);
    check("clear_count", match_count, 0);
    check("clear_keeps_len", cur_len, 1);
    send_vec("saturate", 6, 16'b111111, 16'b111111);
    check("saturate_count", match_count, 3);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    exp_cnt = 0;
    idle(1);
    check("sat_clear_count", match_count, 0);

    // length above MAX_LEN clamps to MAX_LEN; full-width pattern
    configure(8'hA5, 4'd9, 1'b0);
    check("clamp_cur_len_max", cur_len, MAX_LEN);
    send_vec("fullwidth", 8, 16'b10100101, 16'b00000001);
    check("fullwidth_count", match_count, 1);

    // clear and cfg_load together: config loads and counter clears
    configure(8'h0B, 4'd4, 1'b1);
    check("clrload_count", match_count, 0);
    check("clrload_cur_len", cur_len, 4);

    // asynchronous reset mid-pattern
    send_vec("prereset", 4, 16'b1011, 16'b0001);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    @(negedge clk);
    check("prereset_count", match_count, 1);
    #2 reset = 1'b0;
    #1;
    check("async_seq_seen", seq_seen, 0);
    check("async_count", match_count, 0);
    check("async_cur_len", cur_len, MAX_LEN);
    exp_cnt = 0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    configure(8'h0B, 4'd4, 1'b0);
    send_vec("postreset", 5, 16'b11011, 16'b00001);
    check("postreset_count", match_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
